// File: rtl/wb_struct_pkg.sv
// Shared Wishbone B3 types and width constants for the slave memory and its
// burst address generator.
package wb_struct_pkg;

   typedef enum logic [2:0] {
      CLASSIC = 3'b000,
      CONST   = 3'b001,
      INCR    = 3'b010,
      EOB     = 3'b111
   } wb_cti_e;

   typedef enum logic [1:0] {
      LINEAR = 2'b00,
      WRAP4  = 2'b01,
      WRAP8  = 2'b10,
      WRAP16 = 2'b11
   } wb_bte_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      RESP  = 2'b10,
      BURST = 2'b11
   } wb_slv_state_e;

   localparam int unsigned WB_CTI_W    = 3;
   localparam int unsigned WB_BTE_W    = 2;
   localparam int unsigned WB_WAIT_W   = 4;
   localparam int unsigned WB_CNT_W    = 16;
   localparam int unsigned WB_DATA_W32 = 32;
   localparam int unsigned WB_DATA_W64 = 64;

   function automatic int unsigned wb_sel_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Combinational next-beat address for Wishbone incrementing bursts.
// Only the bits inside the wrap span increment; all other bits are preserved.
module wb_burst_addr_gen
   import wb_struct_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned SEL_W      = 4,
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic [ADDR_W-1:0] i_addr,
   input  wb_bte_e           i_bte,
   output logic [ADDR_W-1:0] o_next
);

   localparam int unsigned       BL   = $clog2(SEL_W);
   localparam logic [ADDR_W-1:0] ONES = '1;

   logic [ADDR_W-1:0] w_inc;
   logic [ADDR_W-1:0] w_mask;

   always_comb begin
      w_inc = i_addr + ADDR_W'(SEL_W);
      // Linear bursts wrap at the memory depth, wrap-N at N beats.
      case (i_bte)
         WRAP4:   w_mask = ONES >> (ADDR_W - (BL + 2));
         WRAP8:   w_mask = ONES >> (ADDR_W - (BL + 3));
         WRAP16:  w_mask = ONES >> (ADDR_W - (BL + 4));
         default: w_mask = ONES >> (ADDR_W - (DEPTH_LOG2 + BL));
      endcase
      o_next = (i_addr & ~w_mask) | (w_inc & w_mask);
   end

endmodule

// File: rtl/wb_burst_slave_mem.sv
// Wishbone B3 slave memory with wait states, incrementing/wrapping bursts,
// an error address window and saturating transaction counters.
module wb_burst_slave_mem
   import wb_struct_pkg::*;
#(
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       SEL_W      = wb_sel_w(DATA_W),
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DEPTH_LOG2 = 10,
   parameter logic [ADDR_W-1:0] ERR_BASE   = 32'hFFFF_0000,
   parameter logic [ADDR_W-1:0] ERR_SIZE   = 32'h100
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic [SEL_W-1:0]  wb_sel_i,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic [2:0]        wb_cti_i,
   input  logic [1:0]        wb_bte_i,
   input  logic [3:0]        wait_i,
   output logic [DATA_W-1:0] wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic [15:0]       wr_cnt_o,
   output logic [15:0]       rd_cnt_o,
   output logic [15:0]       burst_cnt_o
);

   localparam int unsigned BL    = $clog2(SEL_W);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   wb_slv_state_e         r_state;
   wb_slv_state_e         w_state_nxt;
   logic [WB_WAIT_W-1:0]  r_wcnt;
   logic [ADDR_W-1:0]     r_addr;
   logic [ADDR_W-1:0]     w_addr_nxt;
   logic [DATA_W-1:0]     r_dat;
   logic [DATA_W-1:0]     r_mem [DEPTH];
   logic [WB_CNT_W-1:0]   r_wr_cnt;
   logic [WB_CNT_W-1:0]   r_rd_cnt;
   logic [WB_CNT_W-1:0]   r_burst_cnt;

   logic                  w_req;
   logic                  w_cur_err;
   logic                  w_beat;
   logic                  w_ack;
   logic                  w_err;
   logic                  w_adv;
   logic                  w_load;
   logic [ADDR_W-1:0]     w_load_addr;
   logic [DEPTH_LOG2-1:0] w_wr_idx;
   logic [DEPTH_LOG2-1:0] w_rd_idx;

   function automatic logic in_window(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - ERR_BASE;
      return (ERR_SIZE != '0) && (off < ERR_SIZE);
   endfunction

   wb_burst_addr_gen #(
      .ADDR_W     (ADDR_W),
      .SEL_W      (SEL_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_addr_gen (
      .i_addr (r_addr),
      .i_bte  (wb_bte_e'(wb_bte_i)),
      .o_next (w_addr_nxt)
   );

   assign w_req     = wb_cyc_i & wb_stb_i;
   assign w_cur_err = in_window(r_addr);
   assign w_beat    = w_req & ((r_state == RESP) | (r_state == BURST));
   assign w_ack     = w_beat & ~w_cur_err;
   assign w_err     = w_beat & w_cur_err;
   assign w_wr_idx  = r_addr[DEPTH_LOG2+BL-1:BL];
   assign w_rd_idx  = w_load_addr[DEPTH_LOG2+BL-1:BL];

   // w_load marks every edge that enters a beat; read data is fetched for
   // the address of that upcoming beat so it is valid alongside its ack.
   always_comb begin
      w_state_nxt = r_state;
      w_adv       = 1'b0;
      w_load      = 1'b0;
      w_load_addr = r_addr;
      if (!wb_cyc_i) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (wb_stb_i) begin
                  if (wait_i != '0) begin
                     w_state_nxt = WAIT;
                  end else begin
                     w_state_nxt = RESP;
                     w_load      = 1'b1;
                     w_load_addr = wb_adr_i;
                  end
               end
            end
            WAIT: begin
               if (r_wcnt == WB_WAIT_W'(1)) begin
                  w_state_nxt = RESP;
                  w_load      = 1'b1;
               end
            end
            RESP: begin
               if ((wb_cti_i == INCR) && !w_cur_err) begin
                  w_state_nxt = BURST;
                  w_adv       = 1'b1;
                  w_load      = 1'b1;
                  w_load_addr = w_addr_nxt;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
            BURST: begin
               if (wb_stb_i) begin
                  if (w_cur_err || (wb_cti_i == EOB)) begin
                     w_state_nxt = IDLE;
                  end else begin
                     w_adv       = 1'b1;
                     w_load      = 1'b1;
                     w_load_addr = w_addr_nxt;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state     <= IDLE;
         r_wcnt      <= '0;
         r_addr      <= '0;
         r_dat       <= '0;
         r_wr_cnt    <= '0;
         r_rd_cnt    <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE) begin
            r_wcnt <= wait_i;
            r_addr <= wb_adr_i;
         end else if (r_state == WAIT) begin
            r_wcnt <= r_wcnt - WB_WAIT_W'(1);
         end
         if (w_adv) begin
            r_addr <= w_addr_nxt;
         end
         if (w_load && !in_window(w_load_addr)) begin
            r_dat <= r_mem[w_rd_idx];
         end
         if (w_ack && wb_we_i && (r_wr_cnt != '1)) begin
            r_wr_cnt <= r_wr_cnt + WB_CNT_W'(1);
         end
         if (w_ack && !wb_we_i && (r_rd_cnt != '1)) begin
            r_rd_cnt <= r_rd_cnt + WB_CNT_W'(1);
         end
         if (w_ack && (r_state == BURST) && (wb_cti_i == EOB) && (r_burst_cnt != '1)) begin
            r_burst_cnt <= r_burst_cnt + WB_CNT_W'(1);
         end
      end
   end

   // Memory is not reset; w_ack is already low while reset holds the FSM.
   always_ff @(posedge wb_clk_i) begin
      if (w_ack && wb_we_i) begin
         for (int unsigned b = 0; b < SEL_W; b++) begin
            if (wb_sel_i[b]) begin
               r_mem[w_wr_idx][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
            end
         end
      end
   end

   assign wb_dat_o    = r_dat;
   assign wb_ack_o    = w_ack;
   assign wb_err_o    = w_err;
   assign wr_cnt_o    = r_wr_cnt;
   assign rd_cnt_o    = r_rd_cnt;
   assign burst_cnt_o = r_burst_cnt;

endmodule

// File: tb/tb_wb_burst_slave_mem.sv
// Self-checking bench for wb_burst_slave_mem: word-level memory model, per-cycle
// ack/err/data/counter comparison, directed scenarios plus randomized traffic.
module tb_wb_burst_slave_mem;

   localparam logic [31:0] WIN_BASE = 32'h0000_1800;
   localparam logic [31:0] WIN_SIZE = 32'h0000_0100;
   localparam int unsigned DEPTH    = 1024;

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
   logic [3:0]  wb_sel_i = '0, wait_i = '0;
   logic [2:0]  wb_cti_i = '0;
   logic [1:0]  wb_bte_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o;
   logic [15:0] wr_cnt_o, rd_cnt_o, burst_cnt_o;

   wb_burst_slave_mem #(
      .DATA_W     (32),
      .ADDR_W     (32),
      .DEPTH_LOG2 (10),
      .ERR_BASE   (WIN_BASE),
      .ERR_SIZE   (WIN_SIZE)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (wb_rst_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_stb_i    (wb_stb_i),
      .wb_we_i     (wb_we_i),
      .wb_adr_i    (wb_adr_i),
      .wb_sel_i    (wb_sel_i),
      .wb_dat_i    (wb_dat_i),
      .wb_cti_i    (wb_cti_i),
      .wb_bte_i    (wb_bte_i),
      .wait_i      (wait_i),
      .wb_dat_o    (wb_dat_o),
      .wb_ack_o    (wb_ack_o),
      .wb_err_o    (wb_err_o),
      .wr_cnt_o    (wr_cnt_o),
      .rd_cnt_o    (rd_cnt_o),
      .burst_cnt_o (burst_cnt_o)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] mem_m [DEPTH];
   bit          mem_k [DEPTH];
   logic [15:0] wr_m = '0, rd_m = '0, burst_m = '0;
   bit          exp_ack = 0, exp_err = 0, exp_chk_dat = 0, chk_en = 0;
   logic [31:0] exp_dat = '0;
   logic [31:0] last_rd = '0;
   int unsigned n_checks = 0, n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned widx(input logic [31:0] a);
      return (a / 4) % DEPTH;
   endfunction

   function automatic bit in_win(input logic [31:0] a);
      return (a >= WIN_BASE) && (a < WIN_BASE + WIN_SIZE);
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] bte);
      int unsigned i, n;
      i = widx(a);
      case (bte)
         2'd1:    n = 4;
         2'd2:    n = 8;
         2'd3:    n = 16;
         default: n = DEPTH;
      endcase
      i = (i / n) * n + ((i % n) + 1) % n;
      return (a & 32'hFFFF_F000) | 32'(i * 4);
   endfunction

   // One bus cycle: publish expectations, then apply the acked beat's effect.
   task automatic tick(input bit ack, input bit err, input logic [31:0] a, input bit eob);
      int unsigned i;
      i           = widx(a);
      exp_ack     = ack;
      exp_err     = err;
      exp_dat     = mem_m[i];
      exp_chk_dat = ack && !wb_we_i && mem_k[i];
      @(posedge clk);
      if (ack) begin
         if (wb_we_i) begin
            for (int b = 0; b < 4; b++)
               if (wb_sel_i[b]) mem_m[i][b*8 +: 8] = wb_dat_i[b*8 +: 8];
            if (wb_sel_i == 4'hF) mem_k[i] = 1;
            if (wr_m != 16'hFFFF) wr_m++;
         end else if (rd_m != 16'hFFFF) begin
            rd_m++;
         end
         if (eob && burst_m != 16'hFFFF) burst_m++;
      end
      #1;
   endtask

   task automatic classic(input bit we, input logic [31:0] a, input logic [3:0] sel,
                          input logic [31:0] d, input logic [3:0] wt);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_sel_i = sel;
      wb_dat_i = d; wb_cti_i = 3'b000; wb_bte_i = 2'b00; wait_i = wt;
      tick(0, 0, a, 0);
      repeat (wt) tick(0, 0, a, 0);
      tick(!in_win(a), in_win(a), a, 0);
      wb_cyc_i = 0; wb_stb_i = 0;
      tick(0, 0, a, 0);
   endtask

   task automatic burst(input bit we, input logic [31:0] start, input logic [1:0] bte,
                        input int unsigned n, input logic [3:0] wt,
                        input int unsigned stall_at, input int unsigned stall_len);
      logic [31:0] a;
      a = start;
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_bte_i = bte; wait_i = wt;
      wb_cti_i = 3'b010; wb_adr_i = a; wb_dat_i = $urandom;
      wb_sel_i = we ? 4'($urandom_range(1, 15)) : 4'hF;
      tick(0, 0, a, 0);
      repeat (wt) tick(0, 0, a, 0);
      for (int unsigned b = 0; b < n; b++) begin
         if (b != 0) begin
            if (b == stall_at && stall_len != 0) begin
               wb_stb_i = 0;
               repeat (stall_len) tick(0, 0, a, 0);
               wb_stb_i = 1;
            end
            wb_cti_i = (b == n - 1) ? 3'b111 : 3'b010;
            wb_adr_i = a; wb_dat_i = $urandom;
            wb_sel_i = we ? 4'($urandom_range(1, 15)) : 4'hF;
         end
         if (in_win(a)) begin
            tick(0, 1, a, 0);
            break;
         end
         tick(1, 0, a, b == n - 1);
         a = next_addr(a, bte);
      end
      wb_cyc_i = 0; wb_stb_i = 0; wb_cti_i = 3'b000;
      tick(0, 0, a, 0);
   endtask

   task automatic pulse_reset();
      wb_rst_i = 1;
      wr_m = '0; rd_m = '0; burst_m = '0;
      tick(0, 0, '0, 0);
      wb_rst_i = 0;
      tick(0, 0, '0, 0);
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("ack", 32'(wb_ack_o), 32'(exp_ack));
         check("err", 32'(wb_err_o), 32'(exp_err));
         check("ack_err_excl", 32'(wb_ack_o & wb_err_o), 32'd0);
         if (exp_chk_dat) check("rdata", wb_dat_o, exp_dat);
         check("wr_cnt", 32'(wr_cnt_o), 32'(wr_m));
         check("rd_cnt", 32'(rd_cnt_o), 32'(rd_m));
         check("burst_cnt", 32'(burst_cnt_o), 32'(burst_m));
         if (wb_ack_o && !wb_we_i) last_rd = wb_dat_o;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      for (int i = 0; i < DEPTH; i++) begin
         mem_m[i] = '0;
         mem_k[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      wb_rst_i = 0;
      chk_en   = 1;
      tick(0, 0, '0, 0);
      check("reset_dat", wb_dat_o, 32'h0);
      check("reset_cnt", {wr_cnt_o, rd_cnt_o}, 32'h0);

      // Preload known contents, then clear counters (memory survives reset)
      burst(1, 32'h0, 2'b00, 64, 0, 0, 0);
      classic(1, 32'h10, 4'hF, 32'h0, 0);
      classic(1, 32'h7F8, 4'hF, 32'hA5A5_0001, 0);
      classic(1, 32'h7FC, 4'hF, 32'hA5A5_0002, 0);
      classic(1, 32'h804, 4'hF, 32'h1234_5678, 0);
      pulse_reset();

      // Partial byte write then full-word read
      classic(1, 32'h10, 4'b0101, 32'hDEAD_BEEF, 0);
      classic(0, 32'h10, 4'b0000, 32'h0, 0);
      check("model_word_0x10", mem_m[4], 32'h00AD_00EF);
      check("read_0x10", last_rd, 32'h00AD_00EF);
      check("wr_cnt_after_rw", 32'(wr_cnt_o), 32'd1);
      check("rd_cnt_after_rw", 32'(rd_cnt_o), 32'd1);

      // Three wait states
      classic(0, 32'h10, 4'hF, 32'h0, 3);

      // Wrap4 read burst from 0x0C
      a = next_addr(32'h0C, 2'b01);
      check("wrap4_addr1", a, 32'h00);
      a = next_addr(a, 2'b01);
      check("wrap4_addr2", a, 32'h04);
      a = next_addr(a, 2'b01);
      check("wrap4_addr3", a, 32'h08);
      burst(0, 32'h0C, 2'b01, 4, 0, 0, 0);
      check("burst_cnt_wrap4", 32'(burst_cnt_o), 32'd1);

      // Linear burst with strobe dropped for 2 cycles
      burst(0, 32'h20, 2'b00, 6, 1, 3, 2);

      // Error window: write rejected, aliased word untouched
      classic(1, WIN_BASE + 32'h4, 4'hF, 32'hFFFF_FFFF, 0);
      check("wr_cnt_after_err", 32'(wr_cnt_o), 32'd1);
      classic(0, 32'h804, 4'hF, 32'h0, 0);
      check("alias_intact", last_rd, 32'h1234_5678);

      // Burst crossing into the window ends with err
      burst(0, 32'h17F8, 2'b00, 4, 0, 0, 0);

      // Reset during WAIT
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h10;
      wb_cti_i = 3'b000; wait_i = 5;
      tick(0, 0, 32'h10, 0);
      tick(0, 0, 32'h10, 0);
      tick(0, 0, 32'h10, 0);
      wb_rst_i = 1;
      wr_m = '0; rd_m = '0; burst_m = '0;
      tick(0, 0, 32'h10, 0);
      tick(0, 0, 32'h10, 0);
      wb_rst_i = 0; wb_cyc_i = 0; wb_stb_i = 0; wait_i = 0;
      tick(0, 0, 32'h10, 0);
      check("rst_wait_cnt", {wr_cnt_o, burst_cnt_o}, 32'h0);
      classic(0, 32'h10, 4'hF, 32'h0, 0);
      check("post_reset_read", last_rd, 32'h00AD_00EF);

      // Randomized traffic
      for (int t = 0; t < 120; t++) begin
         int unsigned r, n;
         r = $urandom_range(0, 9);
         if (r < 7)      a = 32'($urandom_range(0, 63) * 4);
         else if (r < 9) a = 32'h1000 + 32'($urandom_range(0, 63) * 4);
         else            a = WIN_BASE + 32'($urandom_range(0, 63) * 4);
         if ($urandom_range(0, 2) == 0) begin
            classic(1'($urandom_range(0, 1)), a, 4'($urandom_range(1, 15)), $urandom,
                    4'($urandom_range(0, 3)));
         end else begin
            n = $urandom_range(2, 8);
            burst(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), n,
                  4'($urandom_range(0, 3)), $urandom_range(1, n - 1), $urandom_range(0, 2));
         end
      end

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
